dst_ip_prefix_filter: RTL and testbench

Parametrised destination-IP filter for the router output-port lookup pipeline: extracts the IPv4 destination address from the packet header stream, matches it against an internal table of NUM_ENTRIES (address, don't-care mask, enable) entries with lowest-index priority, and queues an in-order (hit, index) result for the process block. Replaces the fixed 32-entry exact-match BRAM-CAM filter. It adds per-entry prefix masks, a returned match index, a configurable result-queue depth and hit/miss/drop statistics, all on a register-based table with no external CAM.

---
 rtl/dst_ip_prefix_filter_pkg.sv | 21 ++
 rtl/dst_ip_prefix_filter_fifo.sv | 52 +++++
 rtl/dst_ip_prefix_filter.sv | 166 ++++++++++++++++
 tb/tb_dst_ip_prefix_filter.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dst_ip_prefix_filter_pkg.sv
// Shared types and constants for the destination-IP prefix filter.
// Holds the table entry layout and the index-width helper.
package dst_ip_prefix_filter_pkg;

    localparam int IP_WIDTH = 32;

    typedef struct packed {
        logic [IP_WIDTH-1:0] ip;
        logic [IP_WIDTH-1:0] mask;
        logic                en;
    } entry_t;

    // Ceiling log2, never below 1 so a one-entry table still has an index bit.
    function automatic int log2_min1(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/dst_ip_prefix_filter_fifo.sv
// Small fall-through FIFO: head word is visible on dout whenever empty is low.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module fallthrough_small_fifo #(
    parameter int WIDTH          = 8,
    parameter int MAX_DEPTH_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 1 << MAX_DEPTH_BITS;

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr;
    logic [MAX_DEPTH_BITS:0]   count;
    logic                      push;
    logic                      pop;

    assign empty = (count == '0);
    assign full  = count[MAX_DEPTH_BITS];
    assign pop   = rd_en && !empty;
    assign push  = wr_en && (!full || pop);
    assign dout  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dst_ip_prefix_filter.sv
// Destination-IP prefix filter: captures the dst IP from header words, matches it
// against a masked register table (lowest index wins) and queues (hit, idx) results.
module dst_ip_prefix_filter
    import dst_ip_prefix_filter_pkg::*;
#(
    parameter int DATA_WIDTH      = 64,
    parameter int NUM_ENTRIES     = 32,
    parameter int IDX_BITS        = log2_min1(NUM_ENTRIES),
    parameter int FIFO_DEPTH_BITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  word_IP_SRC_DST,
    input  logic                  word_IP_DST_LO,
    output logic                  dest_ip_hit,
    output logic [IDX_BITS-1:0]   dest_ip_hit_idx,
    output logic                  dest_ip_filter_vld,
    input  logic                  rd_dest_ip_filter_result,
    input  logic [IDX_BITS-1:0]   dest_ip_filter_rd_addr,
    input  logic                  dest_ip_filter_rd_req,
    output logic [IP_WIDTH-1:0]   dest_ip_filter_rd_ip,
    output logic [IP_WIDTH-1:0]   dest_ip_filter_rd_mask,
    output logic                  dest_ip_filter_rd_en,
    output logic                  dest_ip_filter_rd_ack,
    input  logic [IDX_BITS-1:0]   dest_ip_filter_wr_addr,
    input  logic                  dest_ip_filter_wr_req,
    input  logic [IP_WIDTH-1:0]   dest_ip_filter_wr_ip,
    input  logic [IP_WIDTH-1:0]   dest_ip_filter_wr_mask,
    input  logic                  dest_ip_filter_wr_en,
    output logic                  dest_ip_filter_wr_ack,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count,
    output logic [31:0]           drop_count
);

    localparam logic [IDX_BITS:0] ENTRIES_EXT = (IDX_BITS+1)'(NUM_ENTRIES);

    entry_t                table_q [NUM_ENTRIES];
    logic [IP_WIDTH-1:0]   key;
    logic                  key_vld;
    logic [NUM_ENTRIES-1:0] match_c;
    logic [NUM_ENTRIES-1:0] match_q;
    logic                  match_vld;
    logic                  pe_hit;
    logic [IDX_BITS-1:0]   pe_idx;
    logic [IDX_BITS:0]     head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  pop_ok;
    logic                  wr_ok;
    logic                  rd_ok;

    assign wr_ok = ({1'b0, dest_ip_filter_wr_addr} < ENTRIES_EXT);
    assign rd_ok = ({1'b0, dest_ip_filter_rd_addr} < ENTRIES_EXT);

    // Both halves may load in the same cycle; a lone LO word reuses the stale high half.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key     <= '0;
            key_vld <= 1'b0;
        end else begin
            if (word_IP_SRC_DST) key[31:16] <= in_data[15:0];
            if (word_IP_DST_LO)  key[15:0]  <= in_data[DATA_WIDTH-1 -: 16];
            key_vld <= word_IP_DST_LO;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) table_q[i] <= '0;
        end else if (dest_ip_filter_wr_req && wr_ok) begin
            table_q[dest_ip_filter_wr_addr] <= '{ip:   dest_ip_filter_wr_ip,
                                                 mask: dest_ip_filter_wr_mask,
                                                 en:   dest_ip_filter_wr_en};
        end
    end

    // Reads sample the table before any same-cycle write lands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dest_ip_filter_rd_ip   <= '0;
            dest_ip_filter_rd_mask <= '0;
            dest_ip_filter_rd_en   <= 1'b0;
            dest_ip_filter_rd_ack  <= 1'b0;
            dest_ip_filter_wr_ack  <= 1'b0;
        end else begin
            dest_ip_filter_rd_ack <= dest_ip_filter_rd_req;
            dest_ip_filter_wr_ack <= dest_ip_filter_wr_req;
            if (dest_ip_filter_rd_req) begin
                if (rd_ok) begin
                    dest_ip_filter_rd_ip   <= table_q[dest_ip_filter_rd_addr].ip;
                    dest_ip_filter_rd_mask <= table_q[dest_ip_filter_rd_addr].mask;
                    dest_ip_filter_rd_en   <= table_q[dest_ip_filter_rd_addr].en;
                end else begin
                    dest_ip_filter_rd_ip   <= '0;
                    dest_ip_filter_rd_mask <= '0;
                    dest_ip_filter_rd_en   <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        match_c = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            match_c[i] = table_q[i].en &&
                         (((key ^ table_q[i].ip) & ~table_q[i].mask) == '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            match_q   <= '0;
            match_vld <= 1'b0;
        end else begin
            match_q   <= key_vld ? match_c : '0;
            match_vld <= key_vld;
        end
    end

    // Scan from the top so the lowest matching index is the one left standing.
    always_comb begin
        pe_hit = 1'b0;
        pe_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (match_q[i]) begin
                pe_hit = 1'b1;
                pe_idx = IDX_BITS'(i);
            end
        end
    end

    fallthrough_small_fifo #(
        .WIDTH          (1 + IDX_BITS),
        .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_result_fifo (
        .clk   (clk),
        .reset (reset),
        .din   ({pe_hit, pe_idx}),
        .wr_en (match_vld),
        .rd_en (rd_dest_ip_filter_result),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign pop_ok             = rd_dest_ip_filter_result && !fifo_empty;
    assign dest_ip_filter_vld = !fifo_empty;
    assign dest_ip_hit        = head[IDX_BITS];
    assign dest_ip_hit_idx    = head[IDX_BITS-1:0];

    // Dropped lookups still count as a hit or miss.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_count  <= '0;
            miss_count <= '0;
            drop_count <= '0;
        end else if (match_vld) begin
            if (pe_hit) hit_count  <= hit_count + 32'd1;
            else        miss_count <= miss_count + 32'd1;
            if (fifo_full && !pop_ok) drop_count <= drop_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_dst_ip_prefix_filter.sv
// Directed bench for dst_ip_prefix_filter: a vector table of write+lookup steps,
// then hand sequences for write/lookup races, reads, queue overflow and reset.
module tb_dst_ip_prefix_filter;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_data;
    logic        word_IP_SRC_DST;
    logic        word_IP_DST_LO;
    logic        dest_ip_hit;
    logic [4:0]  dest_ip_hit_idx;
    logic        dest_ip_filter_vld;
    logic        rd_dest_ip_filter_result;
    logic [4:0]  rd_addr;
    logic        rd_req;
    logic [31:0] rd_ip;
    logic [31:0] rd_mask;
    logic        rd_en;
    logic        rd_ack;
    logic [4:0]  wr_addr;
    logic        wr_req;
    logic [31:0] wr_ip;
    logic [31:0] wr_mask;
    logic        wr_en;
    logic        wr_ack;
    logic [31:0] hit_count;
    logic [31:0] miss_count;
    logic [31:0] drop_count;

    int n_vec = 0;
    int n_err = 0;
    int exp_hits = 0;
    int exp_misses = 0;
    int exp_drops = 0;
    logic [5:0] exp_q[$];

    typedef struct {
        logic        do_wr;
        logic [4:0]  addr;
        logic [31:0] ip;
        logic [31:0] mask;
        logic        en;
        logic [31:0] key;
        logic        exp_hit;
        logic [4:0]  exp_idx;
    } vec_t;

    vec_t vecs[12];

    dst_ip_prefix_filter dut (
        .clk                      (clk),
        .reset                    (reset),
        .in_data                  (in_data),
        .word_IP_SRC_DST          (word_IP_SRC_DST),
        .word_IP_DST_LO           (word_IP_DST_LO),
        .dest_ip_hit              (dest_ip_hit),
        .dest_ip_hit_idx          (dest_ip_hit_idx),
        .dest_ip_filter_vld       (dest_ip_filter_vld),
        .rd_dest_ip_filter_result (rd_dest_ip_filter_result),
        .dest_ip_filter_rd_addr   (rd_addr),
        .dest_ip_filter_rd_req    (rd_req),
        .dest_ip_filter_rd_ip     (rd_ip),
        .dest_ip_filter_rd_mask   (rd_mask),
        .dest_ip_filter_rd_en     (rd_en),
        .dest_ip_filter_rd_ack    (rd_ack),
        .dest_ip_filter_wr_addr   (wr_addr),
        .dest_ip_filter_wr_req    (wr_req),
        .dest_ip_filter_wr_ip     (wr_ip),
        .dest_ip_filter_wr_mask   (wr_mask),
        .dest_ip_filter_wr_en     (wr_en),
        .dest_ip_filter_wr_ack    (wr_ack),
        .hit_count                (hit_count),
        .miss_count               (miss_count),
        .drop_count               (drop_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic drive_key(input logic [31:0] ip);
        in_data         = '0;
        in_data[15:0]   = ip[31:16];
        in_data[63:48]  = ip[15:0];
        word_IP_SRC_DST = 1'b1;
        word_IP_DST_LO  = 1'b1;
    endtask

    task automatic clear_key();
        word_IP_SRC_DST = 1'b0;
        word_IP_DST_LO  = 1'b0;
        in_data         = '0;
    endtask

    task automatic set_wr(input logic [4:0] a, input logic [31:0] ip,
                          input logic [31:0] m, input logic e);
        wr_req  = 1'b1;
        wr_addr = a;
        wr_ip   = ip;
        wr_mask = m;
        wr_en   = e;
    endtask

    task automatic count_result(input logic h);
        if (h) exp_hits++;
        else   exp_misses++;
    endtask

    task automatic check_counters(input string tag);
        check({tag, " hit_count"},  hit_count,  32'(exp_hits));
        check({tag, " miss_count"}, miss_count, 32'(exp_misses));
        check({tag, " drop_count"}, drop_count, 32'(exp_drops));
    endtask

    task automatic write_entry(input logic [4:0] a, input logic [31:0] ip,
                               input logic [31:0] m, input logic e);
        @(negedge clk);
        set_wr(a, ip, m, e);
        @(negedge clk);
        wr_req = 1'b0;
        check("wr_ack", wr_ack, 1'b1);
    endtask

    task automatic read_entry(input logic [4:0] a, input logic [31:0] e_ip,
                              input logic [31:0] e_mask, input logic e_en);
        @(negedge clk);
        rd_req  = 1'b1;
        rd_addr = a;
        @(negedge clk);
        rd_req = 1'b0;
        check("rd_ack", rd_ack, 1'b1);
        check("rd_ip", rd_ip, e_ip);
        check("rd_mask", rd_mask, e_mask);
        check("rd_en", rd_en, e_en);
        @(negedge clk);
        check("rd_ack_pulse", rd_ack, 1'b0);
        check("rd_ip_held", rd_ip, e_ip);
    endtask

    // Lookup, check the head exactly three cycles after the LO word, then pop it.
    task automatic lookup_check(input string name, input logic [31:0] key,
                                input logic e_hit, input logic [4:0] e_idx);
        @(negedge clk);
        drive_key(key);
        @(negedge clk);
        clear_key();
        @(negedge clk);
        check({name, " vld_early"}, dest_ip_filter_vld, 1'b0);
        @(negedge clk);
        count_result(e_hit);
        check({name, " vld"}, dest_ip_filter_vld, 1'b1);
        check({name, " hit"}, dest_ip_hit, e_hit);
        check({name, " idx"}, dest_ip_hit_idx, e_idx);
        check_counters(name);
        rd_dest_ip_filter_result = 1'b1;
        @(negedge clk);
        rd_dest_ip_filter_result = 1'b0;
        check({name, " vld_after_pop"}, dest_ip_filter_vld, 1'b0);
    endtask

    task automatic drain_check(input string name);
        logic [5:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({name, " vld"}, dest_ip_filter_vld, 1'b1);
            check({name, " head"}, {dest_ip_hit, dest_ip_hit_idx}, e);
            rd_dest_ip_filter_result = 1'b1;
            @(negedge clk);
        end
        rd_dest_ip_filter_result = 1'b0;
        check({name, " empty"}, dest_ip_filter_vld, 1'b0);
    endtask

    logic [31:0] keys[6];
    logic [5:0]  exps[6];

    initial begin
        vecs[0]  = '{1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 32'hC0A80001, 1'b0, 5'd0};
        vecs[1]  = '{1'b1, 5'd3,  32'h0A000000, 32'h00FFFFFF, 1'b1, 32'h0A010203, 1'b1, 5'd3};
        vecs[2]  = '{1'b1, 5'd2,  32'h0A010000, 32'h0000FFFF, 1'b1, 32'h0A010909, 1'b1, 5'd2};
        vecs[3]  = '{1'b1, 5'd3,  32'h0A000000, 32'h00FFFFFF, 1'b0, 32'h0A010909, 1'b1, 5'd2};
        vecs[4]  = '{1'b1, 5'd5,  32'h0A000000, 32'h00FFFFFF, 1'b1, 32'h0A010909, 1'b1, 5'd2};
        vecs[5]  = '{1'b1, 5'd2,  32'h0A010000, 32'h0000FFFF, 1'b0, 32'h0A010909, 1'b1, 5'd5};
        vecs[6]  = '{1'b1, 5'd0,  32'h00000000, 32'hFFFFFFFF, 1'b0, 32'hC0A80001, 1'b0, 5'd0};
        vecs[7]  = '{1'b1, 5'd0,  32'h00000000, 32'hFFFFFFFF, 1'b1, 32'hC0A80001, 1'b1, 5'd0};
        vecs[8]  = '{1'b1, 5'd0,  32'h00000000, 32'hFFFFFFFF, 1'b0, 32'h0A0000FF, 1'b1, 5'd5};
        vecs[9]  = '{1'b1, 5'd9,  32'h0A0000FF, 32'h00000000, 1'b1, 32'h0A0000FF, 1'b1, 5'd5};
        vecs[10] = '{1'b1, 5'd31, 32'hC0A80001, 32'h00000000, 1'b1, 32'hC0A80001, 1'b1, 5'd31};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        32'h0,        1'b0, 32'hC0A80002, 1'b0, 5'd0};

        // Clock/reset
        reset = 1'b0;
        clear_key();
        rd_dest_ip_filter_result = 1'b0;
        rd_req = 1'b0; rd_addr = '0;
        wr_req = 1'b0; wr_addr = '0; wr_ip = '0; wr_mask = '0; wr_en = 1'b0;
        repeat (3) @(negedge clk);
        check("reset vld", dest_ip_filter_vld, 1'b0);
        check("reset hit", dest_ip_hit, 1'b0);
        check("reset idx", dest_ip_hit_idx, 5'd0);
        check_counters("reset");
        check("reset wr_ack", wr_ack, 1'b0);
        check("reset rd_ack", rd_ack, 1'b0);
        reset = 1'b1;

        // Vector table
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].do_wr) write_entry(vecs[i].addr, vecs[i].ip, vecs[i].mask, vecs[i].en);
            lookup_check($sformatf("vec%0d", i), vecs[i].key, vecs[i].exp_hit, vecs[i].exp_idx);
        end

        // Write in the same cycle as the LO word: compare happens one cycle later.
        write_entry(5'd5, 32'h0A000000, 32'h00FFFFFF, 1'b0);
        @(negedge clk);
        drive_key(32'h0A000001);
        set_wr(5'd7, 32'h0A000001, 32'h0, 1'b1);
        @(negedge clk);
        clear_key();
        wr_req = 1'b0;
        check("race_w0 wr_ack", wr_ack, 1'b1);
        @(negedge clk);
        @(negedge clk);
        count_result(1'b1);
        check("race_w0 vld", dest_ip_filter_vld, 1'b1);
        check("race_w0 hit", dest_ip_hit, 1'b1);
        check("race_w0 idx", dest_ip_hit_idx, 5'd7);
        rd_dest_ip_filter_result = 1'b1;
        @(negedge clk);
        rd_dest_ip_filter_result = 1'b0;

        // Write landing in the compare cycle is too late for that lookup.
        drive_key(32'h0A000002);
        @(negedge clk);
        clear_key();
        set_wr(5'd8, 32'h0A000002, 32'h0, 1'b1);
        @(negedge clk);
        wr_req = 1'b0;
        check("race_late wr_ack", wr_ack, 1'b1);
        @(negedge clk);
        count_result(1'b0);
        check("race_late vld", dest_ip_filter_vld, 1'b1);
        check("race_late hit", dest_ip_hit, 1'b0);
        check("race_late idx", dest_ip_hit_idx, 5'd0);
        rd_dest_ip_filter_result = 1'b1;
        @(negedge clk);
        rd_dest_ip_filter_result = 1'b0;

        // Split header words: high half first, LO word one cycle later.
        in_data = '0;
        in_data[15:0]  = 16'h0A00;
        in_data[63:48] = 16'h1234;
        word_IP_SRC_DST = 1'b1;
        @(negedge clk);
        word_IP_SRC_DST = 1'b0;
        word_IP_DST_LO  = 1'b1;
        in_data[15:0]  = 16'hFFFF;
        in_data[63:48] = 16'h0002;
        @(negedge clk);
        clear_key();
        @(negedge clk);
        @(negedge clk);
        count_result(1'b1);
        check("split vld", dest_ip_filter_vld, 1'b1);
        check("split hit", dest_ip_hit, 1'b1);
        check("split idx", dest_ip_hit_idx, 5'd8);
        check_counters("split");
        rd_dest_ip_filter_result = 1'b1;
        @(negedge clk);
        rd_dest_ip_filter_result = 1'b0;

        // Table reads, including read and write to the same address in one cycle.
        read_entry(5'd7, 32'h0A000001, 32'h0, 1'b1);
        read_entry(5'd3, 32'h0A000000, 32'h00FFFFFF, 1'b0);
        @(negedge clk);
        rd_req = 1'b1; rd_addr = 5'd20;
        set_wr(5'd20, 32'h01010101, 32'h0000FF00, 1'b0);
        @(negedge clk);
        rd_req = 1'b0; wr_req = 1'b0;
        check("rdwr old ack", rd_ack, 1'b1);
        check("rdwr old ip", rd_ip, 32'h0);
        check("rdwr old mask", rd_mask, 32'h0);
        read_entry(5'd20, 32'h01010101, 32'h0000FF00, 1'b0);

        // Six back-to-back lookups into a 4-deep queue with no pops.
        keys[0] = 32'h0A000001; exps[0] = {1'b1, 5'd7};
        keys[1] = 32'h0A000002; exps[1] = {1'b1, 5'd8};
        keys[2] = 32'hC0A80001; exps[2] = {1'b1, 5'd31};
        keys[3] = 32'h01020304; exps[3] = {1'b0, 5'd0};
        keys[4] = 32'h0A0000FF; exps[4] = {1'b1, 5'd9};
        keys[5] = 32'h0A0000FE; exps[5] = {1'b0, 5'd0};
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c < 6) drive_key(keys[c]);
            else       clear_key();
        end
        for (int k = 0; k < 6; k++) begin
            count_result(exps[k][5]);
            if (k < 4) exp_q.push_back(exps[k]);
            else       exp_drops++;
        end
        check_counters("overflow");
        drain_check("overflow");

        // Pop in the same cycle as the fifth push while full: both succeed.
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c < 5) drive_key(keys[c]);
            else       clear_key();
            if (c == 6) check("full_pop head", {dest_ip_hit, dest_ip_hit_idx}, exps[0]);
            rd_dest_ip_filter_result = (c == 6);
        end
        for (int k = 0; k < 5; k++) begin
            count_result(exps[k][5]);
            if (k > 0) exp_q.push_back(exps[k]);
        end
        check_counters("full_pop");
        drain_check("full_pop");

        // Asynchronous reset in the middle of a lookup burst.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            drive_key(keys[c]);
        end
        #2;
        reset = 1'b0;
        #1;
        exp_hits = 0; exp_misses = 0; exp_drops = 0;
        check("midrst vld", dest_ip_filter_vld, 1'b0);
        check("midrst hit", dest_ip_hit, 1'b0);
        check_counters("midrst");
        @(negedge clk);
        clear_key();
        @(negedge clk);
        reset = 1'b1;
        read_entry(5'd7, 32'h0, 32'h0, 1'b0);
        read_entry(5'd31, 32'h0, 32'h0, 1'b0);

        // Pop on an empty queue is ignored.
        @(negedge clk);
        rd_dest_ip_filter_result = 1'b1;
        @(negedge clk);
        rd_dest_ip_filter_result = 1'b0;
        check("empty_pop vld", dest_ip_filter_vld, 1'b0);
        lookup_check("post_reset", 32'h0A000001, 1'b0, 5'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
